// File: rtl/iq_decimator_if.sv
// Sample/control bundle between the complex mixer and the IQ integrate-and-dump decimator.
interface iq_decimator_if #(
    parameter int unsigned W_in       = 16,
    parameter int unsigned LOG2_DECIM = 3
);
    logic signed [W_in-1:0]       real_i;
    logic signed [W_in-1:0]       imag_i;
    logic                         valid_i;
    logic                         sync_i;
    logic signed [W_in-1:0]       real_o;
    logic signed [W_in-1:0]       imag_o;
    logic                         valid_o;
    logic        [LOG2_DECIM-1:0] phase_o;

    modport master (
        output real_i, imag_i, valid_i, sync_i,
        input  real_o, imag_o, valid_o, phase_o
    );

    modport slave (
        input  real_i, imag_i, valid_i, sync_i,
        output real_o, imag_o, valid_o, phase_o
    );
endinterface

// File: rtl/iq_decimator.sv
// Integrate-and-dump decimator: outputs the floor-mean of every 2**LOG2_DECIM valid I/Q samples.
// A sync with valid data restarts the block with the current sample as its first member.
module iq_decimator #(
    parameter int unsigned W_in       = 16,
    parameter int unsigned LOG2_DECIM = 3
) (
    input  logic          clk,
    input  logic          rst,
    iq_decimator_if.slave bus
);
    localparam int unsigned AW    = W_in + LOG2_DECIM;
    localparam int unsigned DECIM = 1 << LOG2_DECIM;
    localparam logic [LOG2_DECIM-1:0] CNT_LAST = LOG2_DECIM'(DECIM - 1);

    logic signed [AW-1:0]         acc_r_q, acc_r_d;
    logic signed [AW-1:0]         acc_i_q, acc_i_d;
    logic        [LOG2_DECIM-1:0] cnt_q, cnt_d;
    logic signed [W_in-1:0]       real_q, real_d;
    logic signed [W_in-1:0]       imag_q, imag_d;
    logic                         valid_q, valid_d;

    logic signed [AW-1:0]         ext_r, ext_i;
    logic signed [AW-1:0]         sum_r, sum_i;

    // Guard bits make the block sum unable to overflow the accumulator.
    assign ext_r = {{LOG2_DECIM{bus.real_i[W_in-1]}}, bus.real_i};
    assign ext_i = {{LOG2_DECIM{bus.imag_i[W_in-1]}}, bus.imag_i};
    assign sum_r = acc_r_q + ext_r;
    assign sum_i = acc_i_q + ext_i;

    always_comb begin
        acc_r_d = acc_r_q;
        acc_i_d = acc_i_q;
        cnt_d   = cnt_q;
        real_d  = real_q;
        imag_d  = imag_q;
        valid_d = 1'b0;
        if (bus.valid_i) begin
            if (bus.sync_i) begin
                acc_r_d = ext_r;
                acc_i_d = ext_i;
                cnt_d   = LOG2_DECIM'(1);
            end else if (cnt_q == CNT_LAST) begin
                // Dropping the low bits of the sum is the arithmetic shift (floor divide).
                real_d  = sum_r[AW-1:LOG2_DECIM];
                imag_d  = sum_i[AW-1:LOG2_DECIM];
                valid_d = 1'b1;
                acc_r_d = '0;
                acc_i_d = '0;
                cnt_d   = '0;
            end else begin
                acc_r_d = sum_r;
                acc_i_d = sum_i;
                cnt_d   = cnt_q + LOG2_DECIM'(1);
            end
        end else if (bus.sync_i) begin
            acc_r_d = '0;
            acc_i_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r_q <= '0;
            acc_i_q <= '0;
            cnt_q   <= '0;
            real_q  <= '0;
            imag_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_r_q <= acc_r_d;
            acc_i_q <= acc_i_d;
            cnt_q   <= cnt_d;
            real_q  <= real_d;
            imag_q  <= imag_d;
            valid_q <= valid_d;
        end
    end

    assign bus.real_o  = real_q;
    assign bus.imag_o  = imag_q;
    assign bus.valid_o = valid_q;
    assign bus.phase_o = cnt_q;
endmodule

// File: tb/tb_iq_decimator.sv
// Directed bench for iq_decimator at DECIM=8, W_in=16 with hand-computed expected outputs.
module tb_iq_decimator;
    localparam int unsigned W  = 16;
    localparam int unsigned LD = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    int   pulses;

    iq_decimator_if #(.W_in(W), .LOG2_DECIM(LD)) bus ();

    iq_decimator #(.W_in(W), .LOG2_DECIM(LD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then observe just after the rising edge.
    task automatic step(input int r, input int im, input logic v, input logic s);
        @(negedge clk);
        bus.real_i  = W'(r);
        bus.imag_i  = W'(im);
        bus.valid_i = v;
        bus.sync_i  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 1'b0, 1'b0);
    endtask

    // Seven samples of (a_r,a_i) followed by a final (l_r,l_i); checks the dump.
    task automatic block(input string tag, input int a_r, input int a_i,
                         input int l_r, input int l_i, input int exp_r, input int exp_i);
        for (int k = 0; k < 7; k++) step(a_r, a_i, 1'b1, 1'b0);
        check({tag, "_pre_valid"}, int'(bus.valid_o), 0);
        step(l_r, l_i, 1'b1, 1'b0);
        check({tag, "_valid"}, int'(bus.valid_o), 1);
        check({tag, "_real"}, int'(bus.real_o), exp_r);
        check({tag, "_imag"}, int'(bus.imag_o), exp_i);
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        bus.real_i  = '0;
        bus.imag_i  = '0;
        bus.valid_i = 1'b0;
        bus.sync_i  = 1'b0;

        rst = 1'b1;
        idle();
        check("rst_valid", int'(bus.valid_o), 0);
        check("rst_real", int'(bus.real_o), 0);
        check("rst_imag", int'(bus.imag_o), 0);
        check("rst_phase", int'(bus.phase_o), 0);
        rst = 1'b0;
        idle();

        // Constant block: pulse exactly one cycle after the 8th sample, held afterwards.
        for (int k = 0; k < 7; k++) step(100, -3, 1'b1, 1'b0);
        check("const_phase7", int'(bus.phase_o), 7);
        check("const_pre_valid", int'(bus.valid_o), 0);
        step(100, -3, 1'b1, 1'b0);
        check("const_valid", int'(bus.valid_o), 1);
        check("const_real", int'(bus.real_o), 100);
        check("const_imag", int'(bus.imag_o), -3);
        check("const_phase0", int'(bus.phase_o), 0);
        idle();
        check("const_pulse_end", int'(bus.valid_o), 0);
        check("const_hold_real", int'(bus.real_o), 100);
        check("const_hold_imag", int'(bus.imag_o), -3);

        // Floor rounding of +1/8 and -1/8.
        block("round_pos", 0, 0, 1, 0, 0, 0);
        block("round_neg", 0, 0, -1, 0, -1, 0);

        // Extremes with valid gapped 1-of-3: idle cycles must not disturb the sum.
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step(32767, -32768, 1'b1, 1'b0);
            if (bus.valid_o) pulses++;
            if (k < 7) begin
                idle();
                if (bus.valid_o) pulses++;
                idle();
                if (bus.valid_o) pulses++;
            end
        end
        check("gap_pulses", pulses, 1);
        check("gap_valid", int'(bus.valid_o), 1);
        check("gap_real", int'(bus.real_o), 32767);
        check("gap_imag", int'(bus.imag_o), -32768);
        idle();
        block("extreme", 32767, -32768, 32767, -32768, 32767, -32768);
        idle();

        // Sync with valid restarts the block; the 1000s never reach the output.
        for (int k = 0; k < 5; k++) step(1000, 1000, 1'b1, 1'b0);
        step(8, 8, 1'b1, 1'b1);
        check("sync_phase", int'(bus.phase_o), 1);
        check("sync_no_dump", int'(bus.valid_o), 0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step(8, 8, 1'b1, 1'b0);
            if (bus.valid_o) pulses++;
        end
        check("sync_early_pulses", pulses, 0);
        step(8, 8, 1'b1, 1'b0);
        check("sync_valid", int'(bus.valid_o), 1);
        check("sync_real", int'(bus.real_o), 8);
        check("sync_imag", int'(bus.imag_o), 8);

        // Sync arriving at cnt=7 with valid must not dump.
        for (int k = 0; k < 7; k++) step(40, 40, 1'b1, 1'b0);
        step(2, 2, 1'b1, 1'b1);
        check("sync_last_no_dump", int'(bus.valid_o), 0);
        check("sync_last_phase", int'(bus.phase_o), 1);
        check("sync_last_hold", int'(bus.real_o), 8);
        step(0, 0, 1'b0, 1'b1);
        check("sync_idle_phase", int'(bus.phase_o), 0);
        check("sync_idle_valid", int'(bus.valid_o), 0);

        // Reset mid-block has priority over valid and clears the outputs.
        for (int k = 0; k < 4; k++) step(500, 500, 1'b1, 1'b0);
        rst = 1'b1;
        step(500, 500, 1'b1, 1'b1);
        check("mrst_valid", int'(bus.valid_o), 0);
        check("mrst_real", int'(bus.real_o), 0);
        check("mrst_imag", int'(bus.imag_o), 0);
        check("mrst_phase", int'(bus.phase_o), 0);
        rst = 1'b0;
        block("post_rst", 16, -16, 16, -16, 16, -16);

        // Continuous ramp: I = 0..63 gives 8k+3; Q = 0..-63 gives -8k-4 (floor of -8k-3.5).
        pulses = 0;
        for (int n = 0; n < 64; n++) begin
            step(n, -n, 1'b1, 1'b0);
            if ((n % 8) == 7) begin
                check($sformatf("ramp_valid_%0d", n / 8), int'(bus.valid_o), 1);
                check($sformatf("ramp_real_%0d", n / 8), int'(bus.real_o), 8 * (n / 8) + 3);
                check($sformatf("ramp_imag_%0d", n / 8), int'(bus.imag_o), -8 * (n / 8) - 4);
            end
            if (bus.valid_o) pulses++;
        end
        check("ramp_pulses", pulses, 8);
        idle();
        check("ramp_end_valid", int'(bus.valid_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
